wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Two-requester Wishbone B4 classic arbiter sitting between the pipeline's memory ports and the shared memory bus. Requester 0 is instruction fetch, requester 1 is the load/store unit. One requester at a time is granted. Its request is latched and driven as a single classic read or write cycle, and the slave's ack/err/data is returned to that requester only.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width (SW = DW/8 select lanes)

Ports (reset is synchronous and active-high):
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  synchronous active-high reset
- mN_addr_i  in  AW  requester N address (N = 0, 1)
- mN_dat_i  in  DW  requester N write data
- mN_sel_i  in  SW  requester N byte select
- mN_we_i  in  1  requester N write request
- mN_re_i  in  1  requester N read request
- mN_ack_o  out  1  one-cycle completion pulse to requester N
- mN_err_o  out  1  one-cycle error pulse to requester N
- mN_dat_o  out  DW  read data to requester N, valid with mN_ack_o
- wbs_cyc_o, wbs_stb_o  out  1  bus cycle/strobe
- wbs_addr_o  out  AW  bus address
- wbs_dat_o  out  DW  bus write data
- wbs_sel_o  out  SW  bus byte select
- wbs_we_o  out  1  bus write enable
- wbs_dat_i  in  DW  bus read data
- wbs_ack_i, wbs_err_i  in  1  bus termination
- gnt_o  out  2  one-hot current owner, 00 when idle

## Operation
- Request from N = mN_we_i | mN_re_i. If both are high, the request is a write.
- The requester holds its request and its addr/dat/sel stable until mN_ack_o or mN_err_o.
- FSM states: IDLE, BUS, DONE.
- IDLE: if any request is present, pick a winner, latch its addr/dat/sel/we into the wbs_* registers, set cyc=stb=1, set gnt_o, go to BUS.
- BUS: hold all wbs_* outputs stable.
  - On wbs_err_i: clear cyc/stb and pulse mN_err_o for the owner. Err wins over a simultaneous ack.
  - Else on wbs_ack_i: clear cyc/stb and pulse mN_ack_o for the owner. For reads, register wbs_dat_i into mN_dat_o.
  - Either termination moves the FSM to DONE.
- DONE: one turnaround cycle so the requester can drop its request. No arbitration. gnt_o = 00. Return to IDLE.
- mN_dat_o holds its last value until the next read completes for that requester. Error terminations do not update it.
- Non-owner ack/err/dat outputs never change.
- Reset values: all ack/err outputs 0; cyc/stb/we 0; addr/dat/sel/mN_dat_o all-zero; gnt_o 00; state IDLE; RR pointer = 1.

## Timing
- Request seen in IDLE at edge N -> cyc/stb high after edge N.
- Slave ack sampled at edge M -> cyc/stb low and mN_ack_o high for the cycle after edge M. DONE covers that cycle, then IDLE.
- Minimum turnaround, zero-wait slave: 3 cycles per transfer. Request-to-ack is 2 cycles.
- No combinational path from any input to any output. All outputs are registered.
- A request arriving during BUS or DONE waits for IDLE.
- Reset asserted mid-BUS: cyc/stb drop after that edge and no ack/err is issued. The requester must reissue its request.

## Configuration
- WB_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit pointer records the last owner.
  - On a tie, the other requester wins.
  - The pointer resets to 1, so m0 wins the first tie.
  - The pointer updates only on a grant.
- WB_ARB_RR_EN undefined: fixed priority, m1 (data) beats m0 (fetch). The pointer logic is absent.

## Structure
- Shared package wb_pkg holds:
  - state enum wb_arb_state_t {IDLE, BUS, DONE}
  - constants WB_AW=32, WB_DW=32, WB_SW=4
- One sub-module, wb_arb_pick: combinational winner selection from the req[1:0] inputs and the RR pointer. Output is a one-hot grant. The macro affects only this sub-module.

## Test plan
- Single read, m0 addr 0x0000_0100, slave acks next cycle with 0xDEAD_BEEF -> wbs_addr_o=0x100, we=0; m0_ack_o pulses for 1 cycle, m0_dat_o=0xDEAD_BEEF; m1 outputs unchanged.
- Single write, m1 addr 0x2000, dat 0x1234_5678, sel 0x3, slave inserts 3 wait states -> cyc/stb/we high for 4 cycles with stable bus fields; m1_ack_o is 1 cycle after ack.
- Simultaneous m0+m1 requests held continuously:
  - Fixed priority: grants are m1, m1, ...
  - RR: grants are m0, m1, m0, m1.
  - In both cases gnt_o is 00 in every DONE cycle.
- wbs_err_i and wbs_ack_i asserted together on an m0 read -> m0_err_o=1, m0_ack_o=0, m0_dat_o unchanged.
- rst_i asserted during BUS with the slave still stalled -> the next cycle shows cyc=stb=0, gnt_o=00 and no ack/err pulse. After reset a held m0 request is re-granted.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and default widths for the Wishbone arbiter slice.
package wb_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  // Arbiter FSM: IDLE arbitrates, BUS runs one classic cycle, DONE is the
  // turnaround cycle that lets the finished requester drop its request.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } wb_arb_state_t;

endpackage

// File: rtl/wb_arb_pick.sv
// Winner selection for the two-requester arbiter.
// WB_ARB_RR_EN defined   : round-robin, a tie goes to the requester that did
//                          not own the bus last (rr_ptr = last owner).
// WB_ARB_RR_EN undefined : fixed priority, m1 (load/store) beats m0 (fetch).
module wb_arb_pick
  import wb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] gnt
);

`ifdef WB_ARB_RR_EN
  // One-hot grant; on a tie the previous owner yields to the other side
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = rr_ptr ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end
`else
  // The pointer has no meaning under fixed priority and is trimmed away
  logic unused_rr_ptr;
  assign unused_rr_ptr = rr_ptr;

  // One-hot grant with the data port always ahead of instruction fetch
  always_comb begin
    gnt = 2'b00;
    if (req[1]) begin
      gnt = 2'b10;
    end else if (req[0]) begin
      gnt = 2'b01;
    end
  end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Two-requester Wishbone B4 classic arbiter (m0 = fetch, m1 = load/store).
// The winner's request is latched and replayed as one classic cycle; the
// termination is routed back to the owner only. Every output is registered.
// Arbitration policy is selected by WB_ARB_RR_EN (see wb_arb_pick).
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int AW = WB_AW,
  parameter int DW = WB_DW,
  localparam int SW = DW / 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_dat_i,
  input  logic [SW-1:0] m0_sel_i,
  input  logic          m0_we_i,
  input  logic          m0_re_i,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic [DW-1:0] m0_dat_o,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_dat_i,
  input  logic [SW-1:0] m1_sel_i,
  input  logic          m1_we_i,
  input  logic          m1_re_i,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [DW-1:0] m1_dat_o,
  output logic          wbs_cyc_o,
  output logic          wbs_stb_o,
  output logic [AW-1:0] wbs_addr_o,
  output logic [DW-1:0] wbs_dat_o,
  output logic [SW-1:0] wbs_sel_o,
  output logic          wbs_we_o,
  input  logic [DW-1:0] wbs_dat_i,
  input  logic          wbs_ack_i,
  input  logic          wbs_err_i,
  output logic [1:0]    gnt_o
);

  wb_arb_state_t state;
  logic [1:0]    req;
  logic [1:0]    pick_gnt;
  logic          rr_ptr;

  // A write request wins over a read request from the same port
  assign req = {m1_we_i | m1_re_i, m0_we_i | m0_re_i};

  wb_arb_pick u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .gnt    (pick_gnt)
  );

  // Arbitration, bus cycle sequencing and per-owner response registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      rr_ptr     <= 1'b1;
      gnt_o      <= 2'b00;
      wbs_cyc_o  <= 1'b0;
      wbs_stb_o  <= 1'b0;
      wbs_we_o   <= 1'b0;
      wbs_addr_o <= '0;
      wbs_dat_o  <= '0;
      wbs_sel_o  <= '0;
      m0_ack_o   <= 1'b0;
      m0_err_o   <= 1'b0;
      m0_dat_o   <= '0;
      m1_ack_o   <= 1'b0;
      m1_err_o   <= 1'b0;
      m1_dat_o   <= '0;
    end else begin
      m0_ack_o <= 1'b0;
      m0_err_o <= 1'b0;
      m1_ack_o <= 1'b0;
      m1_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            if (pick_gnt[1]) begin
              wbs_addr_o <= m1_addr_i;
              wbs_dat_o  <= m1_dat_i;
              wbs_sel_o  <= m1_sel_i;
              wbs_we_o   <= m1_we_i;
            end else begin
              wbs_addr_o <= m0_addr_i;
              wbs_dat_o  <= m0_dat_i;
              wbs_sel_o  <= m0_sel_i;
              wbs_we_o   <= m0_we_i;
            end
            wbs_cyc_o <= 1'b1;
            wbs_stb_o <= 1'b1;
            gnt_o     <= pick_gnt;
            rr_ptr    <= pick_gnt[1];
            state     <= BUS;
          end
        end
        BUS: begin
          if (wbs_err_i) begin
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            wbs_we_o  <= 1'b0;
            m0_err_o  <= gnt_o[0];
            m1_err_o  <= gnt_o[1];
            gnt_o     <= 2'b00;
            state     <= DONE;
          end else if (wbs_ack_i) begin
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            wbs_we_o  <= 1'b0;
            m0_ack_o  <= gnt_o[0];
            m1_ack_o  <= gnt_o[1];
            if (gnt_o[0] && !wbs_we_o) begin
              m0_dat_o <= wbs_dat_i;
            end
            if (gnt_o[1] && !wbs_we_o) begin
              m1_dat_o <= wbs_dat_i;
            end
            gnt_o <= 2'b00;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction-level model of the arbiter.
// Build with WB_ARB_RR_EN defined to check the round-robin policy.
module tb_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] m0_addr_i, m0_dat_i, m1_addr_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m0_re_i, m1_we_i, m1_re_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [31:0] wbs_addr_o, wbs_dat_o, wbs_dat_i;
  logic [3:0]  wbs_sel_o;
  logic        wbs_ack_i, wbs_err_i;
  logic [1:0]  gnt_o;

  int total = 0;
  int bad   = 0;

  // Model state: what each requester is currently asking for, what read data
  // each should be holding, and who owned the bus last.
  logic [31:0] r_addr [2];
  logic [31:0] r_dat  [2];
  logic [3:0]  r_sel  [2];
  logic        r_we   [2];
  bit          pend   [2];
  logic [31:0] exp_dat[2];
  int          last_owner;

  wb_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_addr_i(m0_addr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_we_i(m0_we_i), .m0_re_i(m0_re_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_addr_i(m1_addr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_we_i(m1_we_i), .m1_re_i(m1_re_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_addr_o(wbs_addr_o),
    .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .gnt_o(gnt_o)
  );

  // Free-running 10 ns clock
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int n, input logic we, input logic re,
                               input logic [31:0] addr, input logic [31:0] dat,
                               input logic [3:0] sel);
    r_addr[n] = addr;
    r_dat[n]  = dat;
    r_sel[n]  = sel;
    r_we[n]   = we;
    pend[n]   = we | re;
    if (n == 0) begin
      m0_addr_i = addr; m0_dat_i = dat; m0_sel_i = sel; m0_we_i = we; m0_re_i = re;
    end else begin
      m1_addr_i = addr; m1_dat_i = dat; m1_sel_i = sel; m1_we_i = we; m1_re_i = re;
    end
  endtask

  task automatic dropReq(input int n);
    pend[n] = 1'b0;
    if (n == 0) begin
      m0_we_i = 1'b0; m0_re_i = 1'b0;
    end else begin
      m1_we_i = 1'b0; m1_re_i = 1'b0;
    end
  endtask

  // Policy model: a lone requester always wins; a tie goes to m1 under fixed
  // priority, or to whoever did not own the bus last under round-robin.
  function automatic int modelPick();
    if (pend[0] && !pend[1]) return 0;
    if (pend[1] && !pend[0]) return 1;
`ifdef WB_ARB_RR_EN
    return 1 - last_owner;
`else
    return 1;
`endif
  endfunction

  task automatic checkQuiet(input string tag);
    checkOutput({tag, ".m0_ack"}, 32'(m0_ack_o), 32'd0);
    checkOutput({tag, ".m1_ack"}, 32'(m1_ack_o), 32'd0);
    checkOutput({tag, ".m0_err"}, 32'(m0_err_o), 32'd0);
    checkOutput({tag, ".m1_err"}, 32'(m1_err_o), 32'd0);
  endtask

  task automatic checkData(input string tag);
    checkOutput({tag, ".m0_dat"}, m0_dat_o, exp_dat[0]);
    checkOutput({tag, ".m1_dat"}, m1_dat_o, exp_dat[1]);
  endtask

  // One transfer starting in an IDLE cycle with the owner's request already
  // applied. term: 0 = ack, 1 = err, 2 = err and ack together.
  task automatic doTransfer(input string tag, input int owner, input int waits,
                            input int term, input logic [31:0] rdat,
                            input bit drop);
    logic [1:0] expg;
    expg = (owner == 1) ? 2'b10 : 2'b01;
    last_owner = owner;
    tick();
    for (int i = 0; i <= waits; i++) begin
      checkOutput({tag, ".gnt"},  32'(gnt_o), 32'(expg));
      checkOutput({tag, ".cyc"},  32'(wbs_cyc_o), 32'd1);
      checkOutput({tag, ".stb"},  32'(wbs_stb_o), 32'd1);
      checkOutput({tag, ".we"},   32'(wbs_we_o), 32'(r_we[owner]));
      checkOutput({tag, ".addr"}, wbs_addr_o, r_addr[owner]);
      checkOutput({tag, ".wdat"}, wbs_dat_o, r_dat[owner]);
      checkOutput({tag, ".sel"},  32'(wbs_sel_o), 32'(r_sel[owner]));
      checkQuiet({tag, ".bus"});
      if (i == waits) begin
        wbs_ack_i = (term != 1);
        wbs_err_i = (term != 0);
        wbs_dat_i = rdat;
      end
      tick();
    end
    wbs_ack_i = 1'b0;
    wbs_err_i = 1'b0;
    wbs_dat_i = $urandom;
    if (term == 0 && !r_we[owner]) exp_dat[owner] = rdat;
    checkOutput({tag, ".done_cyc"}, 32'(wbs_cyc_o), 32'd0);
    checkOutput({tag, ".done_stb"}, 32'(wbs_stb_o), 32'd0);
    checkOutput({tag, ".done_gnt"}, 32'(gnt_o), 32'd0);
    checkOutput({tag, ".m0_ack"}, 32'(m0_ack_o), 32'(term == 0 && owner == 0));
    checkOutput({tag, ".m1_ack"}, 32'(m1_ack_o), 32'(term == 0 && owner == 1));
    checkOutput({tag, ".m0_err"}, 32'(m0_err_o), 32'(term != 0 && owner == 0));
    checkOutput({tag, ".m1_err"}, 32'(m1_err_o), 32'(term != 0 && owner == 1));
    checkData(tag);
    if (drop) dropReq(owner);
    tick();
    checkOutput({tag, ".idle_gnt"}, 32'(gnt_o), 32'd0);
    checkOutput({tag, ".idle_cyc"}, 32'(wbs_cyc_o), 32'd0);
    checkQuiet({tag, ".idle"});
  endtask

  // Directed scenarios, then random traffic, then the summary
  initial begin
    int seq[4];
    rst_i = 1'b1;
    wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_dat_i = 32'h0;
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    exp_dat[0] = 32'h0; exp_dat[1] = 32'h0;
    last_owner = 1;
    tick();
    tick();
    checkOutput("rst.cyc",  32'(wbs_cyc_o), 32'd0);
    checkOutput("rst.stb",  32'(wbs_stb_o), 32'd0);
    checkOutput("rst.we",   32'(wbs_we_o), 32'd0);
    checkOutput("rst.addr", wbs_addr_o, 32'd0);
    checkOutput("rst.wdat", wbs_dat_o, 32'd0);
    checkOutput("rst.sel",  32'(wbs_sel_o), 32'd0);
    checkOutput("rst.gnt",  32'(gnt_o), 32'd0);
    checkQuiet("rst");
    checkData("rst");
    rst_i = 1'b0;

    // Both requesters held continuously through four transfers
`ifdef WB_ARB_RR_EN
    seq = '{0, 1, 0, 1};
`else
    seq = '{1, 1, 1, 1};
`endif
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 4'hF);
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_3000, 32'hCAFE_0001, 4'hC);
    for (int k = 0; k < 4; k++) begin
      doTransfer($sformatf("tie%0d", k), seq[k], 0, 0, 32'h1111_0000 + k, 1'b0);
    end
    dropReq(0);
    dropReq(1);
    tick();
    checkOutput("tie.quiet_cyc", 32'(wbs_cyc_o), 32'd0);

    // Single m0 read, zero-wait slave
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'hF);
    doTransfer("read", 0, 0, 0, 32'hDEAD_BEEF, 1'b1);

    // Single m1 write with three wait states
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_2000, 32'h1234_5678, 4'h3);
    doTransfer("write", 1, 3, 0, 32'h5555_AAAA, 1'b1);

    // err and ack together on an m0 read: err wins, read data untouched
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0200, 32'h0, 4'hF);
    doTransfer("errack", 0, 1, 2, 32'h7777_7777, 1'b1);

    // Reset while the slave is stalled, then the held request is re-granted
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_0300, 32'h0, 4'hF);
    tick();
    checkOutput("rstbus.cyc", 32'(wbs_cyc_o), 32'd1);
    checkOutput("rstbus.gnt", 32'(gnt_o), 32'd1);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    exp_dat[0] = 32'h0; exp_dat[1] = 32'h0;
    last_owner = 1;
    checkOutput("rstbus.cyc_low", 32'(wbs_cyc_o), 32'd0);
    checkOutput("rstbus.stb_low", 32'(wbs_stb_o), 32'd0);
    checkOutput("rstbus.gnt_low", 32'(gnt_o), 32'd0);
    checkQuiet("rstbus");
    checkData("rstbus");
    doTransfer("regrant", 0, 0, 0, 32'h0BAD_F00D, 1'b1);

    // Random traffic: new requests appear only while the arbiter is idle
    for (int it = 0; it < 60; it++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && $urandom_range(0, 1) == 1) begin
          logic [1:0] kind;
          kind = 2'($urandom_range(1, 3));
          applyStimulus(n, kind[1], kind[0], $urandom, $urandom, 4'($urandom));
        end
      end
      if (!pend[0] && !pend[1]) begin
        tick();
        checkOutput("rnd.idle_gnt", 32'(gnt_o), 32'd0);
        checkOutput("rnd.idle_cyc", 32'(wbs_cyc_o), 32'd0);
      end else begin
        doTransfer($sformatf("rnd%0d", it), modelPick(), $urandom_range(0, 3),
                   ($urandom_range(0, 5) == 0) ? 1 : 0, $urandom, 1'b1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
